// File: rtl/quadrilatero_csr_access.sv
// rtl/quadrilatero_csr_access.sv - CSR read-modify-write sequencer for offloaded CSR instructions
// Optional macro QUADRILATERO_CSR_RO_CHECK_EN: writes to read-only CSRs respond illegal.
module quadrilatero_csr_access #(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [2:0]          instr_funct3_i,
    input  logic [11:0]         instr_csr_addr_i,
    input  logic [31:0]         instr_rs1_i,
    input  logic [4:0]          instr_uimm_i,
    input  logic [ID_WIDTH-1:0] instr_id_i,
    output logic                csr_re_o,
    output logic                csr_we_o,
    output logic [11:0]         csr_addr_o,
    output logic [31:0]         csr_wdata_o,
    input  logic [31:0]         csr_rdata_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [31:0]         resp_rdata_o,
    output logic                resp_illegal_o,
    output logic [ID_WIDTH-1:0] resp_id_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t              state;
    logic                ready_q;
    logic                re_q;
    logic                we_q;
    logic [11:0]         addr_q;
    logic [1:0]          op_q;
    logic [31:0]         operand_q;
    logic [ID_WIDTH-1:0] id_q;
    logic                ro_q;
    logic                wr_q;
    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_illegal_q;
    logic [ID_WIDTH-1:0] resp_id_q;

    logic        addr_known;
    logic        instr_legal;
    logic        instr_writes;
    logic [31:0] operand_in;
    logic [31:0] new_value;
    logic        ro_fault;

    always_comb begin
        addr_known = 1'b0;
        case (instr_csr_addr_i)
            12'h801, 12'h802, 12'h803, 12'hCC0, 12'hCC1, 12'hCC2: addr_known = 1'b1;
            default: addr_known = 1'b0;
        endcase
    end

    assign instr_legal  = (instr_funct3_i[1:0] != 2'b00) && addr_known;
    // Set/clear forms with a zero immediate/index are pure reads.
    assign instr_writes = (instr_funct3_i[1:0] == 2'b01) || (instr_uimm_i != 5'd0);
    assign operand_in   = instr_funct3_i[2] ? {27'd0, instr_uimm_i} : instr_rs1_i;

    always_comb begin
        new_value = operand_q;
        case (op_q)
            2'b10:   new_value = csr_rdata_i | operand_q;
            2'b11:   new_value = csr_rdata_i & ~operand_q;
            default: new_value = operand_q;
        endcase
    end

`ifdef QUADRILATERO_CSR_RO_CHECK_EN
    assign ro_fault = ro_q & wr_q;
`else
    assign ro_fault = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            ready_q        <= 1'b1;
            re_q           <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            op_q           <= '0;
            operand_q      <= '0;
            id_q           <= '0;
            ro_q           <= 1'b0;
            wr_q           <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_illegal_q <= 1'b0;
            resp_id_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid_i) begin
                        ready_q   <= 1'b0;
                        op_q      <= instr_funct3_i[1:0];
                        operand_q <= operand_in;
                        id_q      <= instr_id_i;
                        ro_q      <= (instr_csr_addr_i[11:10] == 2'b11);
                        wr_q      <= instr_writes;
                        if (instr_legal) begin
                            state  <= READ;
                            re_q   <= 1'b1;
                            addr_q <= instr_csr_addr_i;
                        end else begin
                            state          <= RESP;
                            resp_valid_q   <= 1'b1;
                            resp_rdata_q   <= '0;
                            resp_illegal_q <= 1'b1;
                            resp_id_q      <= instr_id_i;
                        end
                    end
                end
                READ: begin
                    state <= WRITE;
                    re_q  <= 1'b0;
                    we_q  <= wr_q & ~ro_q;
                end
                WRITE: begin
                    state          <= RESP;
                    we_q           <= 1'b0;
                    addr_q         <= '0;
                    resp_valid_q   <= 1'b1;
                    resp_rdata_q   <= ro_fault ? 32'd0 : csr_rdata_i;
                    resp_illegal_q <= ro_fault;
                    resp_id_q      <= id_q;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by reset so an in-flight access cannot fire in the reset cycle.
    assign instr_ready_o  = ready_q;
    assign csr_re_o       = re_q & ~rst_i;
    assign csr_we_o       = we_q & ~rst_i;
    assign csr_addr_o     = addr_q;
    assign csr_wdata_o    = csr_we_o ? new_value : 32'd0;
    assign resp_valid_o   = resp_valid_q & ~rst_i;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_illegal_o = resp_illegal_q;
    assign resp_id_o      = resp_id_q;

endmodule

// File: tb/tb_quadrilatero_csr_access.sv
// tb/tb_quadrilatero_csr_access.sv - directed vector bench for quadrilatero_csr_access
module tb_quadrilatero_csr_access;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [2:0]  instr_funct3_i;
    logic [11:0] instr_csr_addr_i;
    logic [31:0] instr_rs1_i;
    logic [4:0]  instr_uimm_i;
    logic [3:0]  instr_id_i;
    logic        csr_re_o;
    logic        csr_we_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_illegal_o;
    logic [3:0]  resp_id_o;

    int passed = 0;
    int total  = 0;

    quadrilatero_csr_access #(.ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_funct3_i(instr_funct3_i), .instr_csr_addr_i(instr_csr_addr_i),
        .instr_rs1_i(instr_rs1_i), .instr_uimm_i(instr_uimm_i), .instr_id_i(instr_id_i),
        .csr_re_o(csr_re_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_illegal_o(resp_illegal_o), .resp_id_o(resp_id_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef QUADRILATERO_CSR_RO_CHECK_EN
    localparam bit RO_CHK = 1'b1;
`else
    localparam bit RO_CHK = 1'b0;
`endif

    typedef struct {
        logic [2:0]  funct3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  uimm;
        logic [3:0]  id;
        logic [31:0] rdata;
        logic        exp_read;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                         input logic [4:0] uimm, input logic [3:0] id);
        instr_valid_i    = 1'b1;
        instr_funct3_i   = f3;
        instr_csr_addr_i = a;
        instr_rs1_i      = rs1;
        instr_uimm_i     = uimm;
        instr_id_i       = id;
        step();
        instr_valid_i    = 1'b0;
        instr_funct3_i   = 3'b000;
        instr_csr_addr_i = 12'h000;
        instr_rs1_i      = 32'hFFFF_FFFF;
        instr_uimm_i     = 5'h1F;
        instr_id_i       = 4'h0;
    endtask

    task automatic apply(input int n, input vec_t v);
        string t;
        t = $sformatf("v%0d", n);
        chk({t, "_ready_idle"}, instr_ready_o, 1);
        issue(v.funct3, v.addr, v.rs1, v.uimm, v.id);
        if (v.exp_read) begin
            chk({t, "_re"}, csr_re_o, 1);
            chk({t, "_re_addr"}, csr_addr_o, v.addr);
            chk({t, "_we_in_read"}, csr_we_o, 0);
            chk({t, "_valid_early"}, resp_valid_o, 0);
            csr_rdata_i = 32'hDEAD_BEEF;
            step();
            csr_rdata_i = v.rdata;
            #1;
            chk({t, "_re_off"}, csr_re_o, 0);
            chk({t, "_we"}, csr_we_o, v.exp_we);
            chk({t, "_wdata"}, csr_wdata_o, v.exp_we ? v.exp_wdata : 32'd0);
            if (v.exp_we) chk({t, "_we_addr"}, csr_addr_o, v.addr);
            step();
            csr_rdata_i = 32'hDEAD_BEEF;
            chk({t, "_we_off"}, csr_we_o, 0);
        end else begin
            chk({t, "_no_re"}, csr_re_o, 0);
            chk({t, "_no_we"}, csr_we_o, 0);
        end
        chk({t, "_valid"}, resp_valid_o, 1);
        chk({t, "_rdata"}, resp_rdata_o, v.exp_rdata);
        chk({t, "_illegal"}, resp_illegal_o, v.exp_illegal);
        chk({t, "_id"}, resp_id_o, v.id);
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        chk({t, "_valid_drop"}, resp_valid_o, 0);
        chk({t, "_ready_back"}, instr_ready_o, 1);
    endtask

    initial begin
        vecs[0]  = '{3'b001, 12'h802, 32'hA5,        5'd0,  4'h1, 32'h3,    1, 1, 32'hA5,   32'h3,  0};
        vecs[1]  = '{3'b110, 12'h801, 32'h1234,      5'd0,  4'h2, 32'h10,   1, 0, 32'h0,    32'h10, 0};
        vecs[2]  = '{3'b011, 12'h803, 32'h0F,        5'd5,  4'h3, 32'hFF,   1, 1, 32'hF0,   32'hFF, 0};
        vecs[3]  = '{3'b100, 12'h802, 32'h1,         5'd1,  4'h4, 32'h0,    0, 0, 32'h0,    32'h0,  1};
        vecs[4]  = '{3'b001, 12'h7C0, 32'h1,         5'd0,  4'h5, 32'h0,    0, 0, 32'h0,    32'h0,  1};
        vecs[5]  = '{3'b001, 12'hCC2, 32'h1,         5'd0,  4'h6, 32'h10,   1, 0, 32'h0,
                     RO_CHK ? 32'h0 : 32'h10, RO_CHK};
        vecs[6]  = '{3'b010, 12'h801, 32'h0F00,      5'd3,  4'h7, 32'hF1,   1, 1, 32'hFF1,  32'hF1, 0};
        vecs[7]  = '{3'b101, 12'h803, 32'hFFFF_FFFF, 5'h1F, 4'h8, 32'h7,    1, 1, 32'h1F,   32'h7,  0};
        vecs[8]  = '{3'b111, 12'h802, 32'h0,         5'd6,  4'h9, 32'hF,    1, 1, 32'h9,    32'hF,  0};
        vecs[9]  = '{3'b000, 12'h801, 32'h5,         5'd2,  4'hA, 32'h0,    0, 0, 32'h0,    32'h0,  1};
        vecs[10] = '{3'b110, 12'hCC0, 32'h0,         5'd0,  4'hB, 32'h40,   1, 0, 32'h0,    32'h40, 0};
        vecs[11] = '{3'b111, 12'hCC1, 32'h0,         5'd1,  4'hC, 32'h20,   1, 0, 32'h0,
                     RO_CHK ? 32'h0 : 32'h20, RO_CHK};

        rst_i = 1'b1;
        instr_valid_i = 1'b0;
        instr_funct3_i = 3'b000;
        instr_csr_addr_i = 12'h0;
        instr_rs1_i = 32'h0;
        instr_uimm_i = 5'd0;
        instr_id_i = 4'h0;
        csr_rdata_i = 32'h0;
        resp_ready_i = 1'b0;
        step();
        step();
        chk("rst_re", csr_re_o, 0);
        chk("rst_we", csr_we_o, 0);
        chk("rst_addr", csr_addr_o, 0);
        chk("rst_wdata", csr_wdata_o, 0);
        chk("rst_valid", resp_valid_o, 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_illegal", resp_illegal_o, 0);
        chk("rst_id", resp_id_o, 0);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", instr_ready_o, 1);

        for (int i = 0; i < 12; i++) apply(i, vecs[i]);

        // Reset while the write strobe is up must kill the write and the response.
        issue(3'b001, 12'h802, 32'h77, 5'd0, 4'h3);
        chk("rw_re", csr_re_o, 1);
        step();
        rst_i = 1'b1;
        csr_rdata_i = 32'h1;
        #1;
        chk("rw_we_masked", csr_we_o, 0);
        chk("rw_wdata_masked", csr_wdata_o, 0);
        step();
        rst_i = 1'b0;
        #1;
        chk("rw_ready", instr_ready_o, 1);
        chk("rw_no_resp", resp_valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rw_quiet_resp", resp_valid_o, 0);
            chk("rw_quiet_we", csr_we_o, 0);
            chk("rw_quiet_re", csr_re_o, 0);
        end

        // Stalled response stays stable; a request at the handshake edge is not taken.
        issue(3'b001, 12'h801, 32'h99, 5'd0, 4'hA);
        step();
        csr_rdata_i = 32'h55;
        step();
        csr_rdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", resp_valid_o, 1);
            chk("stall_rdata", resp_rdata_o, 32'h55);
            chk("stall_illegal", resp_illegal_o, 0);
            chk("stall_id", resp_id_o, 4'hA);
            chk("stall_ready", instr_ready_o, 0);
            step();
        end
        resp_ready_i = 1'b1;
        instr_valid_i = 1'b1;
        instr_funct3_i = 3'b000;
        instr_id_i = 4'h5;
        step();
        resp_ready_i = 1'b0;
        instr_valid_i = 1'b0;
        chk("hs_valid_drop", resp_valid_o, 0);
        chk("hs_ready", instr_ready_o, 1);
        step();
        chk("hs_not_taken", resp_valid_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
